// File: rtl/csa_iter_subtractor.sv
// Iterative X - Y subtractor: SLICE bits per clock through a chain of
// 2-bit carry-select units, with valid/ready handshakes on both sides.
module csa_iter_subtractor #(
    parameter int WIDTH = 128,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             Ovf
);

    localparam int N  = WIDTH / SLICE;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t            state, state_n;
    logic [IW-1:0]     idx;
    logic              c;
    logic [WIDTH-1:0]  xr, yr;
    logic [SLICE-1:0]  xs, ys, sum;
    logic [SLICE:0]    cy;
    logic              last;

    assign xs    = xr[idx*SLICE +: SLICE];
    assign ys    = yr[idx*SLICE +: SLICE];
    assign cy[0] = c;
    assign last  = (idx == IW'(N - 1));

    // Each unit resolves its LSB, then picks the precomputed MSB/carry pair.
    for (genvar k = 0; k < SLICE / 2; k++) begin : g_cs
        logic a0, b0, a1, b1, p1;
        assign a0 = xs[2*k];
        assign b0 = ys[2*k];
        assign a1 = xs[2*k+1];
        assign b1 = ys[2*k+1];
        assign p1 = a1 ^ b1;
        assign sum[2*k]   = a0 ^ b0 ^ cy[2*k];
        assign cy[2*k+1]  = (a0 & b0) | (cy[2*k] & (a0 ^ b0));
        assign sum[2*k+1] = cy[2*k+1] ? ~p1 : p1;
        assign cy[2*k+2]  = cy[2*k+1] ? (a1 | b1) : (a1 & b1);
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (in_valid) state_n = RUN;
            RUN:  if (last) state_n = DONE;
            DONE: if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            c     <= 1'b1;
            xr    <= '0;
            yr    <= '0;
            Diff  <= '0;
            Bout  <= 1'b0;
            Ovf   <= 1'b0;
        end else begin
            state <= state_n;
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        xr   <= X;
                        yr   <= ~Y;
                        c    <= 1'b1;
                        idx  <= '0;
                        Diff <= '0;
                    end
                end
                RUN: begin
                    Diff[idx*SLICE +: SLICE] <= sum;
                    c   <= cy[SLICE];
                    idx <= last ? '0 : idx + 1'b1;
                    // yr holds ~Y, so equal MSBs mean the operands differ in sign.
                    if (last) begin
                        Bout <= ~cy[SLICE];
                        Ovf  <= (xr[WIDTH-1] == yr[WIDTH-1]) &&
                                (sum[SLICE-1] != xr[WIDTH-1]);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_csa_iter_subtractor.sv
// Randomized and directed bench for csa_iter_subtractor against an
// arithmetic reference model.
module tb_csa_iter_subtractor;

    localparam int W   = 128;
    localparam int LAT = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] X = '0;
    logic [W-1:0] Y = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] Diff;
    logic         Bout;
    logic         Ovf;

    int checks = 0;
    int failures = 0;

    csa_iter_subtractor #(.WIDTH(W), .SLICE(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .X        (X),
        .Y        (Y),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .Diff     (Diff),
        .Bout     (Bout),
        .Ovf      (Ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full operation: accept, time the latency, check result, optional stall.
    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y,
                         input int hold);
        logic [W:0]   wide;
        logic [W-1:0] ed;
        logic         eb, eo;
        int           n;
        wide = {x[W-1], x} - {y[W-1], y};
        ed   = x - y;
        eb   = (x < y);
        eo   = (wide[W] != wide[W-1]);
        chk("idle_rdy", W'(in_ready), W'(1));
        out_ready = (hold == 0);
        in_valid  = 1'b1;
        X = x;
        Y = y;
        tick();
        in_valid = 1'b0;
        X = rnd128();
        Y = rnd128();
        chk("run_rdy", W'(in_ready), W'(0));
        n = 0;
        do begin
            tick();
            n++;
            if (n < LAT && out_valid) break;
        end while (!out_valid && n < 40);
        chk("latency", W'(n), W'(LAT));
        chk("diff", Diff, ed);
        chk("bout", W'(Bout), W'(eb));
        chk("ovf", W'(Ovf), W'(eo));
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                in_valid = 1'b1;
                X = rnd128();
                Y = rnd128();
                tick();
                chk("hold_vld", W'(out_valid), W'(1));
                chk("hold_rdy", W'(in_ready), W'(0));
                chk("hold_diff", Diff, ed);
                chk("hold_flags", W'({Bout, Ovf}), W'({eb, eo}));
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        tick();
        chk("ret_vld", W'(out_valid), W'(0));
        chk("ret_rdy", W'(in_ready), W'(1));
        chk("ret_diff", Diff, ed);
    endtask

    initial begin
        logic [W-1:0] one;
        int           bad;
        one = W'(1);
        #12;
        chk("rst_diff", Diff, '0);
        chk("rst_flags", W'({out_valid, Bout, Ovf}), W'(0));
        chk("rst_rdy", W'(in_ready), W'(1));
        rst_n = 1'b1;
        tick();

        // Reset in the middle of RUN discards the operation.
        in_valid = 1'b1;
        X = W'(5);
        Y = W'(3);
        tick();
        in_valid = 1'b0;
        repeat (7) tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_diff", Diff, '0);
        chk("mid_rst_out", W'({out_valid, Bout, Ovf}), W'(0));
        chk("mid_rst_rdy", W'(in_ready), W'(1));
        #3;
        rst_n = 1'b1;
        bad = 0;
        repeat (25) begin
            tick();
            if (out_valid) bad++;
        end
        chk("mid_rst_novld", W'(bad), W'(0));

        do_op(W'(10), W'(3), 0);
        do_op(W'(0), W'(1), 0);
        do_op(one << 64, W'(1), 0);
        do_op((one << 127) - one, '1, 0);
        do_op(one << 127, W'(1), 0);
        do_op(W'(77), W'(77), 0);
        do_op(rnd128(), rnd128(), 5);
        do_op(rnd128(), rnd128(), 0);

        for (int t = 0; t < 24; t++) begin
            logic [W-1:0] a, b;
            a = rnd128();
            b = (t % 4 == 0) ? a + W'($urandom_range(0, 3)) : rnd128();
            if (t % 5 == 1) b = ~a;
            do_op(a, b, int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
